lfsr_hex_display: RTL and testbench

//  Parametrised Fibonacci LFSR with debounced push-button control and N-digit hex

---
 rtl/lfsr_disp_pkg.sv | 18 +
 rtl/btn_debounce.sv | 49 ++++
 rtl/lfsr_hex_display.sv | 107 ++++++++++
 tb/tb_lfsr_hex_display.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_disp_pkg.sv
// Shared constants for the LFSR hex display: seven-segment code table,
// default feedback mask and seed.
package lfsr_disp_pkg;

  localparam logic [7:0] DEFAULT_TAPS = 8'h1D;
  localparam logic [7:0] DEFAULT_SEED = 8'h01;

  // Active-low {a,b,c,d,e,f,g,dp}; entry n is the glyph for nibble n, dp always off.
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
    8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03
  };

  function automatic logic [7:0] hex7seg(input logic [3:0] nib);
    hex7seg = SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, consecutive-cycle debouncer and one-cycle press pulse
// for a single raw push-button.
module btn_debounce
  import lfsr_disp_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Synchronise, count disagreeing cycles, flip the level and flag rising flips.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        cnt_r   <= '0;
        level_r <= sync2_r;
        press_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/lfsr_hex_display.sv
// Fibonacci LFSR driven by debounced step / run-toggle / reload buttons, with the
// state shown as hex digits on active-low seven-segment outputs.
module lfsr_hex_display
  import lfsr_disp_pkg::*;
#(
  parameter int              WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS        = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED        = WIDTH'(DEFAULT_SEED),
  parameter int              DEBOUNCE_CYC = 4,
  parameter int              AUTO_DIV     = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           btn,
  output logic [WIDTH-1:0]     lfsr_out,
  output logic [2*WIDTH-1:0]   seg,
  output logic                 running
);

  localparam int DIGITS = WIDTH / 4;
  localparam int TW     = $clog2(AUTO_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(AUTO_DIV - 1);

  logic [2:0]         press_s;
  logic               tick_s;
  logic               step_s;
  logic [WIDTH-1:0]   stepped_s;
  logic [WIDTH-1:0]   lfsr_nxt_s;
  logic [2*WIDTH-1:0] seg_nxt_s;
  logic [2*WIDTH-1:0] seg_seed_s;
  logic [TW-1:0]      tick_cnt_r;
  logic               running_r;
  logic [WIDTH-1:0]   lfsr_r;
  logic [2*WIDTH-1:0] seg_r;
  logic               unused_btn_s;

  assign unused_btn_s = ^btn[4:3];

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn[i]),
      .press (press_s[i])
    );
  end

  // Auto-run tick: only meaningful while running.
  always_comb begin
    tick_s = running_r && (tick_cnt_r == TICK_LAST);
  end

  // Run/stop toggle and the auto-run period counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      running_r  <= 1'b0;
      tick_cnt_r <= '0;
    end else if (press_s[1]) begin
      running_r  <= ~running_r;
      tick_cnt_r <= '0;
    end else if (!running_r || tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + 1'b1;
    end
  end

  // Next LFSR value: reload beats step; a step that would lock up at zero reseeds.
  always_comb begin
    stepped_s  = {^(lfsr_r & TAPS), lfsr_r[WIDTH-1:1]};
    step_s     = press_s[0] | tick_s;
    lfsr_nxt_s = lfsr_r;
    if (press_s[2]) begin
      lfsr_nxt_s = SEED;
    end else if (step_s) begin
      if (stepped_s == '0) begin
        lfsr_nxt_s = SEED;
      end else begin
        lfsr_nxt_s = stepped_s;
      end
    end else begin
      lfsr_nxt_s = lfsr_r;
    end
  end

  // Segments are encoded from the next state so they never lag the LFSR.
  for (genvar k = 0; k < DIGITS; k++) begin : g_seg
    assign seg_nxt_s[8*k +: 8]  = hex7seg(lfsr_nxt_s[4*k +: 4]);
    assign seg_seed_s[8*k +: 8] = hex7seg(SEED[4*k +: 4]);
  end

  // LFSR and display registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= SEED;
      seg_r  <= seg_seed_s;
    end else begin
      lfsr_r <= lfsr_nxt_s;
      seg_r  <= seg_nxt_s;
    end
  end

  assign lfsr_out = lfsr_r;
  assign seg      = seg_r;
  assign running  = running_r;

endmodule

// File: tb/tb_lfsr_hex_display.sv
// Scoreboard bench for lfsr_hex_display: three instances (8-bit demo, 16-bit
// maximal, 8-bit lock-up) with expectations queued at stimulus time.
module tb_lfsr_hex_display;

  typedef struct {
    logic [31:0] v;
    logic [63:0] s;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_a;
  logic        rst_b;
  logic [4:0]  btn8;
  logic [4:0]  btn16;
  logic [4:0]  btnlk;
  logic [7:0]  lfsr8;
  logic [15:0] seg8;
  logic        running8;
  logic [15:0] lfsr16;
  logic [31:0] seg16;
  logic        running16;
  logic [7:0]  lfsrlk;
  logic [15:0] seglk;
  logic        runninglk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q8[$];
  exp_t q16[$];
  exp_t qlk[$];
  logic [31:0] m8;
  logic [31:0] m16;
  logic [31:0] mlk;

  localparam int N16 = 20000;
  localparam int NLK = 20;

  lfsr_hex_display #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .DEBOUNCE_CYC(4), .AUTO_DIV(10)) dut8 (
    .clk(clk), .rst(rst_a), .btn(btn8), .lfsr_out(lfsr8), .seg(seg8), .running(running8));

  lfsr_hex_display #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'hACE1), .DEBOUNCE_CYC(2), .AUTO_DIV(2)) dut16 (
    .clk(clk), .rst(rst_b), .btn(btn16), .lfsr_out(lfsr16), .seg(seg16), .running(running16));

  lfsr_hex_display #(.WIDTH(8), .TAPS(8'h00), .SEED(8'h80), .DEBOUNCE_CYC(1), .AUTO_DIV(2)) dutlk (
    .clk(clk), .rst(rst_b), .btn(btnlk), .lfsr_out(lfsrlk), .seg(seglk), .running(runninglk));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] tb_seg(input logic [3:0] n);
    case (n)
      4'h0: return 8'h03;  4'h1: return 8'h9F;  4'h2: return 8'h25;  4'h3: return 8'h0D;
      4'h4: return 8'h99;  4'h5: return 8'h49;  4'h6: return 8'h41;  4'h7: return 8'h1F;
      4'h8: return 8'h01;  4'h9: return 8'h09;  4'hA: return 8'h11;  4'hB: return 8'hC1;
      4'hC: return 8'h63;  4'hD: return 8'h85;  4'hE: return 8'h61;  default: return 8'h71;
    endcase
  endfunction

  function automatic logic [63:0] enc(input logic [31:0] v, input int nd);
    logic [63:0] s;
    s = 64'd0;
    for (int k = 0; k < nd; k++) s[8*k +: 8] = tb_seg(v[4*k +: 4]);
    return s;
  endfunction

  function automatic logic [31:0] model_step(input logic [31:0] x, input logic [31:0] taps,
                                             input logic [31:0] seed, input int w);
    logic [31:0] r;
    r = (x >> 1) | ({31'd0, ^(x & taps)} << (w - 1));
    if (r == 32'd0) r = seed;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push8(input logic reload, input int c);
    m8 = reload ? 32'h01 : model_step(m8, 32'h1D, 32'h01, 8);
    q8.push_back('{v: m8, s: enc(m8, 2), cyc: c});
  endtask

  task automatic tap_step8();
    int t0;
    @(negedge clk);
    t0 = cyc;
    push8(1'b0, t0 + 7);
    btn8[0] = 1'b1;
    wait_until(t0 + 8);
    btn8[0] = 1'b0;
    wait_until(t0 + 20);
  endtask

  // Monitor: every visible output change pops one expectation.
  initial begin : monitor
    logic [31:0] pv[3];
    logic [63:0] ps[3];
    logic [31:0] cv;
    logic [63:0] cs;
    logic        rs;
    logic        got;
    exp_t        e;
    string       tag;
    for (int i = 0; i < 3; i++) begin
      pv[i] = 32'd0;
      ps[i] = 64'd0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        case (i)
          0:       begin cv = 32'(lfsr8);  cs = 64'(seg8);  rs = rst_a; tag = "dut8";  end
          1:       begin cv = 32'(lfsr16); cs = 64'(seg16); rs = rst_b; tag = "dut16"; end
          default: begin cv = 32'(lfsrlk); cs = 64'(seglk); rs = rst_b; tag = "dutlk"; end
        endcase
        if (rs) begin
          pv[i] = cv;
          ps[i] = cs;
        end else if (cv != pv[i] || cs != ps[i]) begin
          pv[i] = cv;
          ps[i] = cs;
          got = 1'b0;
          if (i == 0 && q8.size() != 0) begin e = q8.pop_front(); got = 1'b1; end
          else if (i == 1 && q16.size() != 0) begin e = q16.pop_front(); got = 1'b1; end
          else if (i == 2 && qlk.size() != 0) begin e = qlk.pop_front(); got = 1'b1; end
          if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_change actual=%h expected=no_change at cycle %0d", tag, cv, cyc);
          end else begin
            chk({tag, "_lfsr"}, 64'(cv), 64'(e.v));
            chk({tag, "_seg"}, cs, e.s);
            chk({tag, "_step_cycle"}, 64'(cyc), 64'(e.cyc));
            chk({tag, "_nonzero"}, 64'(cv != 32'd0), 64'd1);
          end
        end
      end
    end
  end

  task automatic run_a();
    int t0;
    int tt;
    #3;
    chk("rst8_lfsr", 64'(lfsr8), 64'h01);
    chk("rst8_seg", 64'(seg8), 64'h039F);
    chk("rst8_running", 64'(running8), 64'd0);
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);

    // Clean presses with latency checked by the monitor.
    tap_step8();
    chk("press1_lfsr", 64'(lfsr8), 64'h80);
    chk("press1_seg", 64'(seg8), 64'h0103);
    tap_step8();
    chk("press2_lfsr", 64'(lfsr8), 64'h40);
    chk("press2_seg", 64'(seg8), 64'h9903);

    // Short bounces must not step; a long hold steps exactly once.
    for (int h = 1; h <= 3; h++) begin
      @(negedge clk);
      btn8[0] = 1'b1;
      repeat (h) @(negedge clk);
      btn8[0] = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("bounce_no_step", 64'(lfsr8), 64'h40);
    @(negedge clk);
    t0 = cyc;
    push8(1'b0, t0 + 7);
    btn8[0] = 1'b1;
    wait_until(t0 + 30);
    btn8[0] = 1'b0;
    wait_until(t0 + 45);
    chk("long_hold_one_step", 64'(lfsr8), 64'h20);

    // Auto-run every 10 cycles, then stop.
    @(negedge clk);
    t0 = cyc;
    tt = t0 + 7;
    for (int k = 1; k <= 3; k++) push8(1'b0, tt + 10 * k);
    btn8[1] = 1'b1;
    wait_until(tt - 1);
    chk("run_before_toggle", 64'(running8), 64'd0);
    wait_until(tt);
    chk("run_after_toggle", 64'(running8), 64'd1);
    wait_until(t0 + 8);
    btn8[1] = 1'b0;
    wait_until(t0 + 35);
    btn8[1] = 1'b1;
    wait_until(t0 + 43);
    btn8[1] = 1'b0;
    wait_until(tt + 60);
    chk("run_stopped", 64'(running8), 64'd0);
    chk("auto_steps_done", 64'(q8.size()), 64'd0);

    // Tick coincident with press0, then reload coincident with tick.
    @(negedge clk);
    t0 = cyc;
    tt = t0 + 7;
    push8(1'b0, tt + 10);
    push8(1'b0, tt + 20);
    push8(1'b1, tt + 30);
    push8(1'b0, tt + 40);
    btn8[1] = 1'b1;
    wait_until(t0 + 8);
    btn8[1] = 1'b0;
    wait_until(tt + 13);
    btn8[0] = 1'b1;
    wait_until(tt + 21);
    btn8[0] = 1'b0;
    wait_until(tt + 23);
    btn8[2] = 1'b1;
    wait_until(tt + 31);
    btn8[2] = 1'b0;
    wait_until(tt + 33);
    btn8[1] = 1'b1;
    wait_until(tt + 41);
    btn8[1] = 1'b0;
    wait_until(tt + 60);
    chk("coincide_running", 64'(running8), 64'd0);
    chk("coincide_lfsr", 64'(lfsr8), 64'h80);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    t0 = cyc;
    btn8[1] = 1'b1;
    wait_until(t0 + 8);
    btn8[1] = 1'b0;
    wait_until(t0 + 9);
    chk("pre_reset_running", 64'(running8), 64'd1);
    @(posedge clk);
    #3;
    rst_a = 1'b1;
    #1;
    chk("midrst_lfsr", 64'(lfsr8), 64'h01);
    chk("midrst_seg", 64'(seg8), 64'h039F);
    chk("midrst_running", 64'(running8), 64'd0);
    m8 = 32'h01;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    repeat (30) @(negedge clk);
    chk("post_reset_idle", 64'(lfsr8), 64'h01);
  endtask

  task automatic run_b();
    int t0;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    chk("rst16_lfsr", 64'(lfsr16), 64'hACE1);
    chk("rst16_seg", 64'(seg16), 64'h1163619F);
    chk("rstlk_seg", 64'(seglk), 64'h0103);
    @(negedge clk);
    t0 = cyc;
    for (int k = 1; k <= N16; k++) begin
      m16 = model_step(m16, 32'hB400, 32'hACE1, 16);
      q16.push_back('{v: m16, s: enc(m16, 4), cyc: t0 + 5 + 2 * k});
    end
    for (int k = 1; k <= NLK; k++) begin
      mlk = model_step(mlk, 32'h00, 32'h80, 8);
      qlk.push_back('{v: mlk, s: enc(mlk, 2), cyc: t0 + 4 + 2 * k});
    end
    btn16[1] = 1'b1;
    btnlk[1] = 1'b1;
    wait_until(t0 + 6);
    chk("lk_first_step", 64'(lfsrlk), 64'h40);
    btn16[1] = 1'b0;
    btnlk[1] = 1'b0;
    wait_until(t0 + 7);
    chk("w16_first_step", 64'(lfsr16), 64'hD670);
    wait_until(t0 + 40);
    btnlk[1] = 1'b1;
    wait_until(t0 + 46);
    btnlk[1] = 1'b0;
    wait_until(t0 + 2 * N16);
    btn16[1] = 1'b1;
    wait_until(t0 + 2 * N16 + 6);
    btn16[1] = 1'b0;
    wait_until(t0 + 2 * N16 + 30);
    chk("w16_stopped", 64'(running16), 64'd0);
    chk("lk_stopped", 64'(runninglk), 64'd0);
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    btn8  = 5'd0;
    btn16 = 5'd0;
    btnlk = 5'd0;
    m8    = 32'h01;
    m16   = 32'hACE1;
    mlk   = 32'h80;
    fork
      run_a();
      run_b();
    join
    repeat (5) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q16_drained", 64'(q16.size()), 64'd0);
    chk("qlk_drained", 64'(qlk.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
